// File: rtl/prefetch_burst_queue.sv
// Prefetch burst queue: a ring of burst slots filled by a slave read stream and
// drained by a master reader. Each slot holds one burst and a promise count:
// the number of master reads still owed. Slots stay resident after being read,
// so a later master hit replays the data. A slot nobody wants any more is
// skip-popped once the slot behind it is owed.
//
// Ports
//   clk, resetN            clock, async active-low reset
//   burstLen               beats-1 per burst (static while non-empty)
//   crs_almostFullSpacer   almost-full margin in slots
//   alloc_*                allocation request (master read or prefetch), hit lookup
//   slv_*                  incoming beat stream, written into the fill slot
//   mst_*                  outgoing beat stream from the head slot
//   flush                  drop every slot next edge
//   prefetchReqCnt, validCnt, almostFull, hasOutstanding  status
//   errorCode              one-cycle registered error report
module prefetch_burst_queue #(
    parameter int unsigned LOG_QUEUE_SIZE = 3,
    parameter int unsigned LOG_BURST_MAX  = 2,
    parameter int unsigned DATA_BITS      = 512,
    parameter int unsigned ADDR_BITS      = 64,
    parameter int unsigned PROMISE_WIDTH  = 3
) (
    input  logic                      clk,
    input  logic                      resetN,
    input  logic [LOG_BURST_MAX-1:0]  burstLen,
    input  logic [LOG_QUEUE_SIZE-1:0] crs_almostFullSpacer,
    input  logic                      alloc_valid,
    output logic                      alloc_ready,
    input  logic [ADDR_BITS-1:0]      alloc_addr,
    input  logic                      alloc_isPref,
    output logic                      alloc_hit,
    input  logic                      slv_valid,
    output logic                      slv_ready,
    input  logic [DATA_BITS-1:0]      slv_data,
    input  logic                      slv_last,
    output logic                      mst_valid,
    input  logic                      mst_ready,
    output logic [DATA_BITS-1:0]      mst_data,
    output logic [ADDR_BITS-1:0]      mst_addr,
    output logic                      mst_last,
    input  logic                      flush,
    output logic [LOG_QUEUE_SIZE:0]   prefetchReqCnt,
    output logic [LOG_QUEUE_SIZE:0]   validCnt,
    output logic                      almostFull,
    output logic                      hasOutstanding,
    output logic [2:0]                errorCode
);

    localparam int unsigned QS = 1 << LOG_QUEUE_SIZE;
    localparam int unsigned BM = 1 << LOG_BURST_MAX;
    localparam int unsigned CW = LOG_QUEUE_SIZE + 1;
    localparam int unsigned AW = LOG_QUEUE_SIZE + 2;
    localparam int unsigned QW = LOG_QUEUE_SIZE;
    localparam int unsigned BW = LOG_BURST_MAX;
    localparam int unsigned PW = PROMISE_WIDTH;

    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_SLV_DROP = 3'd2;
    localparam logic [2:0] ERR_ALLOC    = 3'd3;
    localparam logic [2:0] ERR_LAST     = 3'd4;
    localparam logic [2:0] ERR_PREF_HIT = 3'd5;
    localparam logic [2:0] ERR_PROM_SAT = 3'd6;

    // slot state
    logic [QS-1:0]        slot_valid, slot_valid_d;
    logic [QS-1:0]        slot_pref, slot_pref_d;
    logic [ADDR_BITS-1:0] slot_addr [QS];
    logic [ADDR_BITS-1:0] slot_addr_d [QS];
    logic [PW-1:0]        slot_promise [QS];
    logic [PW-1:0]        slot_promise_d [QS];
    logic [BM-1:0]        beat_valid [QS];
    logic [BM-1:0]        beat_valid_d [QS];
    logic [DATA_BITS-1:0] beat_data [QS][BM];

    // pointers and counters
    logic [QW-1:0] head, head_d, tail, tail_d, fill, fill_d;
    logic [BW-1:0] wr_beat, wr_beat_d, rd_beat, rd_beat_d;
    logic [CW-1:0] valid_cnt, valid_cnt_d;
    logic [2:0]    err_d;

    // derived
    logic [QS-1:0] slot_done;
    logic          hit_found;
    logic [QW-1:0] hit_idx;
    logic          full;
    logic [QW-1:0] head_next;
    logic          wr_fire, wr_last, rd_fire, rd_last;
    logic          alloc_new, alloc_inc, promise_sat, pop;
    logic [CW-1:0] pref_cnt;
    logic          outstanding;

    // a slot is complete once beats 0..burstLen are all present
    always_comb begin
        for (int i = 0; i < QS; i++) begin
            slot_done[i] = 1'b1;
            for (int b = 0; b < BM; b++) begin
                if ((BW'(b) <= burstLen) && !beat_valid[i][b]) begin
                    slot_done[i] = 1'b0;
                end
            end
        end
    end

    // address lookup across valid slots
    always_comb begin
        hit_found = 1'b0;
        hit_idx   = '0;
        for (int i = 0; i < QS; i++) begin
            if (!hit_found && slot_valid[i] && (slot_addr[i] == alloc_addr)) begin
                hit_found = 1'b1;
                hit_idx   = QW'(i);
            end
        end
    end

    // status counts
    always_comb begin
        pref_cnt    = '0;
        outstanding = 1'b0;
        for (int i = 0; i < QS; i++) begin
            if (slot_valid[i] && slot_pref[i]) begin
                pref_cnt = pref_cnt + CW'(1);
            end
            if (slot_valid[i] && !slot_done[i]) begin
                outstanding = 1'b1;
            end
        end
    end

    assign full           = (valid_cnt == CW'(QS));
    assign alloc_hit      = hit_found;
    assign alloc_ready    = !full || hit_found;
    assign slv_ready      = slot_valid[fill] && !slot_done[fill];
    assign mst_valid      = slot_valid[head] && (slot_promise[head] != '0) && beat_valid[head][rd_beat];
    assign mst_data       = beat_data[head][rd_beat];
    assign mst_addr       = slot_addr[head];
    assign mst_last       = (rd_beat == burstLen);
    assign validCnt       = valid_cnt;
    assign prefetchReqCnt = pref_cnt;
    assign hasOutstanding = outstanding;
    assign almostFull     = (AW'(valid_cnt) + AW'(crs_almostFullSpacer)) >= AW'(QS);

    assign head_next   = head + QW'(1);
    assign wr_fire     = slv_valid && slv_ready;
    assign wr_last     = (wr_beat == burstLen);
    assign rd_fire     = mst_valid && mst_ready;
    assign rd_last     = rd_fire && mst_last;
    assign promise_sat = (slot_promise[hit_idx] == {PW{1'b1}});
    assign alloc_new   = alloc_valid && !hit_found && !full;
    assign alloc_inc   = alloc_valid && hit_found && !alloc_isPref && !promise_sat;
    // an allocation hitting the head keeps it resident
    assign pop = slot_valid[head] && (slot_promise[head] == '0) && slot_done[head]
              && slot_valid[head_next] && (slot_promise[head_next] != '0)
              && !(alloc_valid && hit_found && (hit_idx == head));

    // next-state for slots, pointers, counters and error report
    always_comb begin
        slot_valid_d = slot_valid;
        slot_pref_d  = slot_pref;
        for (int i = 0; i < QS; i++) begin
            slot_addr_d[i]    = slot_addr[i];
            slot_promise_d[i] = slot_promise[i];
            beat_valid_d[i]   = beat_valid[i];
        end
        head_d      = head;
        tail_d      = tail;
        fill_d      = fill;
        wr_beat_d   = wr_beat;
        rd_beat_d   = rd_beat;
        valid_cnt_d = valid_cnt;
        err_d       = ERR_NONE;

        if (flush) begin
            slot_valid_d = '0;
            slot_pref_d  = '0;
            for (int i = 0; i < QS; i++) begin
                slot_addr_d[i]    = '0;
                slot_promise_d[i] = '0;
                beat_valid_d[i]   = '0;
            end
            head_d      = '0;
            tail_d      = '0;
            fill_d      = '0;
            wr_beat_d   = '0;
            rd_beat_d   = '0;
            valid_cnt_d = '0;
        end else begin
            if (slv_valid && !slv_ready) begin
                err_d = ERR_SLV_DROP;
            end else if (alloc_valid && !alloc_ready) begin
                err_d = ERR_ALLOC;
            end else if (wr_fire && (slv_last != wr_last)) begin
                err_d = ERR_LAST;
            end else if (alloc_valid && alloc_isPref && hit_found) begin
                err_d = ERR_PREF_HIT;
            end else if (alloc_valid && !alloc_isPref && hit_found && promise_sat) begin
                err_d = ERR_PROM_SAT;
            end

            if (rd_fire) begin
                rd_beat_d = rd_last ? '0 : rd_beat + BW'(1);
            end

            // a mismatched slv_last is reported but the beat is still stored
            if (wr_fire) begin
                beat_valid_d[fill][wr_beat] = 1'b1;
                wr_beat_d = wr_last ? '0 : wr_beat + BW'(1);
                if (wr_last) begin
                    fill_d = fill + QW'(1);
                end
            end

            if (alloc_inc) begin
                slot_promise_d[hit_idx] = slot_promise[hit_idx] + PW'(1);
                slot_pref_d[hit_idx]    = 1'b0;
            end
            if (rd_last) begin
                slot_promise_d[head] = slot_promise_d[head] - PW'(1);
            end

            if (alloc_new) begin
                slot_valid_d[tail]   = 1'b1;
                slot_pref_d[tail]    = alloc_isPref;
                slot_addr_d[tail]    = alloc_addr;
                slot_promise_d[tail] = alloc_isPref ? PW'(0) : PW'(1);
                beat_valid_d[tail]   = '0;
                tail_d               = tail + QW'(1);
            end

            if (pop) begin
                slot_valid_d[head] = 1'b0;
                slot_pref_d[head]  = 1'b0;
                head_d             = head_next;
            end

            valid_cnt_d = valid_cnt + CW'(alloc_new) - CW'(pop);
        end
    end

    // control state register
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            slot_valid <= '0;
            slot_pref  <= '0;
            for (int i = 0; i < QS; i++) begin
                slot_addr[i]    <= '0;
                slot_promise[i] <= '0;
                beat_valid[i]   <= '0;
            end
            head      <= '0;
            tail      <= '0;
            fill      <= '0;
            wr_beat   <= '0;
            rd_beat   <= '0;
            valid_cnt <= '0;
            errorCode <= ERR_NONE;
        end else begin
            slot_valid <= slot_valid_d;
            slot_pref  <= slot_pref_d;
            for (int i = 0; i < QS; i++) begin
                slot_addr[i]    <= slot_addr_d[i];
                slot_promise[i] <= slot_promise_d[i];
                beat_valid[i]   <= beat_valid_d[i];
            end
            head      <= head_d;
            tail      <= tail_d;
            fill      <= fill_d;
            wr_beat   <= wr_beat_d;
            rd_beat   <= rd_beat_d;
            valid_cnt <= valid_cnt_d;
            errorCode <= err_d;
        end
    end

    // beat storage; validity is tracked separately so no reset is needed
    always_ff @(posedge clk) begin
        if (wr_fire && !flush) begin
            beat_data[fill][wr_beat] <= slv_data;
        end
    end

endmodule

// File: tb/tb_prefetch_burst_queue.sv
// Bench for prefetch_burst_queue: directed scenarios with literal expectations
// plus a queue-based model compared against every output on each falling edge.
module tb_prefetch_burst_queue;

    localparam int unsigned QS = 4;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic [1:0]  burstLen = 2'd3;
    logic [1:0]  crs_almostFullSpacer = 2'd1;
    logic        alloc_valid = 1'b0;
    logic        alloc_ready;
    logic [31:0] alloc_addr = '0;
    logic        alloc_isPref = 1'b0;
    logic        alloc_hit;
    logic        slv_valid = 1'b0;
    logic        slv_ready;
    logic [31:0] slv_data = '0;
    logic        slv_last = 1'b0;
    logic        mst_valid;
    logic        mst_ready = 1'b0;
    logic [31:0] mst_data;
    logic [31:0] mst_addr;
    logic        mst_last;
    logic        flush = 1'b0;
    logic [2:0]  prefetchReqCnt;
    logic [2:0]  validCnt;
    logic        almostFull;
    logic        hasOutstanding;
    logic [2:0]  errorCode;

    prefetch_burst_queue #(
        .LOG_QUEUE_SIZE(2), .LOG_BURST_MAX(2), .DATA_BITS(32), .ADDR_BITS(32), .PROMISE_WIDTH(3)
    ) dut (
        .clk(clk), .resetN(resetN), .burstLen(burstLen), .crs_almostFullSpacer(crs_almostFullSpacer),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_addr(alloc_addr),
        .alloc_isPref(alloc_isPref), .alloc_hit(alloc_hit),
        .slv_valid(slv_valid), .slv_ready(slv_ready), .slv_data(slv_data), .slv_last(slv_last),
        .mst_valid(mst_valid), .mst_ready(mst_ready), .mst_data(mst_data), .mst_addr(mst_addr),
        .mst_last(mst_last), .flush(flush), .prefetchReqCnt(prefetchReqCnt), .validCnt(validCnt),
        .almostFull(almostFull), .hasOutstanding(hasOutstanding), .errorCode(errorCode)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- model: slots in queue order, head first ----------------
    typedef struct packed {
        logic             is_pref;
        logic [31:0]      addr;
        logic [7:0]       promise;
        logic [2:0]       nbeats;
        logic [3:0][31:0] data;
    } slot_t;

    slot_t m_q[$];
    int    m_rd  = 0;
    int    m_err = 0;

    function automatic int m_find(input logic [31:0] a);
        for (int i = 0; i < m_q.size(); i++) if (m_q[i].addr == a) return i;
        return -1;
    endfunction

    function automatic int m_fill();
        for (int i = 0; i < m_q.size(); i++) if (int'(m_q[i].nbeats) <= int'(burstLen)) return i;
        return -1;
    endfunction

    function automatic bit m_mvalid();
        return (m_q.size() > 0) && (m_q[0].promise != 0) && (int'(m_q[0].nbeats) > m_rd);
    endfunction

    function automatic int m_pref_cnt();
        int n = 0;
        for (int i = 0; i < m_q.size(); i++) if (m_q[i].is_pref) n++;
        return n;
    endfunction

    int    mh, mf, me;
    bit    mfull, mardy, msr, mmv, mpop;
    slot_t ms;

    // model update on each edge from the pre-edge state
    initial forever begin
        @(posedge clk or negedge resetN);
        if (!resetN || flush) begin
            m_q.delete();
            m_rd  = 0;
            m_err = 0;
        end else begin
            mh    = m_find(alloc_addr);
            mf    = m_fill();
            mfull = (m_q.size() == QS);
            mardy = !mfull || (mh >= 0);
            msr   = (mf >= 0);
            mmv   = m_mvalid();
            me    = 0;
            if (slv_valid && !msr) me = 2;
            else if (alloc_valid && !mardy) me = 3;
            else if (slv_valid && msr && (slv_last != (int'(m_q[mf].nbeats) == int'(burstLen)))) me = 4;
            else if (alloc_valid && alloc_isPref && mh >= 0) me = 5;
            else if (alloc_valid && !alloc_isPref && mh >= 0 && m_q[mh].promise == 7) me = 6;
            mpop = (m_q.size() >= 2) && (m_q[0].promise == 0) &&
                   (int'(m_q[0].nbeats) == int'(burstLen) + 1) && (m_q[1].promise != 0) &&
                   !(alloc_valid && mh == 0);
            if (mmv && mst_ready) begin
                if (m_rd == int'(burstLen)) begin
                    m_rd = 0;
                    ms = m_q[0]; ms.promise = ms.promise - 8'd1; m_q[0] = ms;
                end else begin
                    m_rd++;
                end
            end
            if (slv_valid && msr) begin
                ms = m_q[mf];
                ms.data[ms.nbeats[1:0]] = slv_data;
                ms.nbeats = ms.nbeats + 3'd1;
                m_q[mf] = ms;
            end
            if (alloc_valid) begin
                if (mh >= 0) begin
                    if (!alloc_isPref && m_q[mh].promise != 7) begin
                        ms = m_q[mh]; ms.promise = ms.promise + 8'd1; ms.is_pref = 1'b0; m_q[mh] = ms;
                    end
                end else if (!mfull) begin
                    ms = '0;
                    ms.is_pref = alloc_isPref;
                    ms.addr    = alloc_addr;
                    ms.promise = alloc_isPref ? 8'd0 : 8'd1;
                    m_q.push_back(ms);
                end
            end
            if (mpop) void'(m_q.pop_front());
            m_err = me;
        end
    end

    // compare every output against the model on the falling edge
    initial forever begin
        @(negedge clk);
        chk("alloc_hit", alloc_hit, m_find(alloc_addr) >= 0);
        chk("alloc_ready", alloc_ready, (m_q.size() < QS) || (m_find(alloc_addr) >= 0));
        chk("slv_ready", slv_ready, m_fill() >= 0);
        chk("validCnt", validCnt, m_q.size());
        chk("prefetchReqCnt", prefetchReqCnt, m_pref_cnt());
        chk("almostFull", almostFull, (m_q.size() + int'(crs_almostFullSpacer)) >= QS);
        chk("hasOutstanding", hasOutstanding, m_fill() >= 0);
        chk("errorCode", errorCode, m_err);
        chk("mst_valid", mst_valid, m_mvalid());
        if (m_mvalid() && mst_valid) begin
            chk("mst_data", mst_data, m_q[0].data[m_rd]);
            chk("mst_last", mst_last, m_rd == int'(burstLen));
            chk("mst_addr", mst_addr, m_q[0].addr);
        end
    end

    // ---------------- stimulus ----------------
    logic [31:0] cap_d [16];
    logic        cap_l [16];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_alloc(input logic [31:0] a, input logic pref);
        alloc_valid = 1'b1; alloc_addr = a; alloc_isPref = pref;
        tick();
        alloc_valid = 1'b0;
    endtask

    task automatic do_beat(input logic [31:0] d, input logic last);
        slv_valid = 1'b1; slv_data = d; slv_last = last;
        tick();
        slv_valid = 1'b0; slv_last = 1'b0;
    endtask

    task automatic do_burst(input logic [31:0] base);
        for (int i = 0; i < 4; i++) do_beat(base + 32'(i), i == 3);
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_validCnt", validCnt, 0);
    endtask

    task automatic drain(input int n);
        int cnt = 0;
        mst_ready = 1'b1;
        for (int c = 0; c < 60 && cnt < n; c++) begin
            if (mst_valid) begin
                cap_d[cnt] = mst_data;
                cap_l[cnt] = mst_last;
                cnt++;
            end
            tick();
        end
        mst_ready = 1'b0;
        chk("drain_count", cnt, n);
    endtask

    task automatic chk_caps(input string nm, input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            chk({nm, "_data"}, cap_d[i], base + 32'(i % 4));
            chk({nm, "_last"}, cap_l[i], (i % 4) == 3);
        end
    endtask

    initial begin
        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_validCnt", validCnt, 0);
        chk("rst_alloc_ready", alloc_ready, 1);
        chk("rst_alloc_hit", alloc_hit, 0);
        chk("rst_mst_valid", mst_valid, 0);
        chk("rst_slv_ready", slv_ready, 0);
        chk("rst_almostFull", almostFull, 0);
        chk("rst_errorCode", errorCode, 0);
        resetN = 1'b1;
        tick();

        // master read, single delivery
        do_alloc(32'h1000, 1'b0);
        chk("s1_validCnt", validCnt, 1);
        chk("s1_slv_ready", slv_ready, 1);
        chk("s1_outstanding", hasOutstanding, 1);
        do_burst(32'hA000_0000);
        drain(4);
        chk_caps("s1", 4, 32'hA000_0000);
        chk("s1_idle", mst_valid, 0);
        chk("s1_retained", validCnt, 1);

        // prefetch claimed by a later master read
        do_flush();
        do_alloc(32'h1000, 1'b1);
        chk("s2_pref_cnt1", prefetchReqCnt, 1);
        do_burst(32'hB000_0000);
        chk("s2_no_read", mst_valid, 0);
        alloc_valid = 1'b1; alloc_addr = 32'h1000; alloc_isPref = 1'b0;
        #1;
        chk("s2_hit", alloc_hit, 1);
        tick();
        alloc_valid = 1'b0;
        chk("s2_validCnt", validCnt, 1);
        chk("s2_pref_cnt0", prefetchReqCnt, 0);
        drain(4);
        chk_caps("s2", 4, 32'hB000_0000);

        // unclaimed prefetch skip-popped by a newer master read
        do_flush();
        do_alloc(32'h1000, 1'b1);
        do_burst(32'hC000_0000);
        do_alloc(32'h2000, 1'b0);
        chk("s3_two", validCnt, 2);
        do_burst(32'hC100_0000);
        chk("s3_popped", validCnt, 1);
        chk("s3_addr", mst_addr, 32'h2000);
        drain(4);
        chk_caps("s3", 4, 32'hC100_0000);
        chk("s3_end", validCnt, 1);

        // full queue, drop on miss, accept on hit with replay
        do_flush();
        for (int i = 1; i <= 4; i++) do_alloc(32'(i) << 12, 1'b0);
        chk("s4_full", validCnt, 4);
        chk("s4_almostFull", almostFull, 1);
        alloc_valid = 1'b1; alloc_addr = 32'h5000; alloc_isPref = 1'b0;
        #1;
        chk("s4_not_ready", alloc_ready, 0);
        tick();
        alloc_valid = 1'b0;
        chk("s4_err3", errorCode, 3);
        tick();
        chk("s4_err_clear", errorCode, 0);
        alloc_valid = 1'b1; alloc_addr = 32'h1000;
        #1;
        chk("s4_hit_ready", alloc_ready, 1);
        tick();
        alloc_valid = 1'b0;
        do_burst(32'hD000_0000);
        drain(8);
        chk_caps("s4", 8, 32'hD000_0000);
        tick();
        chk("s4_pop", validCnt, 3);

        // slv_last mismatch, then reset in the middle of a read
        do_flush();
        do_alloc(32'h1000, 1'b0);
        do_beat(32'hE000_0000, 1'b1);
        chk("s5_err4", errorCode, 4);
        do_beat(32'hE000_0001, 1'b0);
        do_beat(32'hE000_0002, 1'b0);
        do_beat(32'hE000_0003, 1'b1);
        mst_ready = 1'b1;
        tick();
        tick();
        #1;
        resetN = 1'b0;
        #1;
        chk("s5_rst_mst_valid", mst_valid, 0);
        chk("s5_rst_validCnt", validCnt, 0);
        chk("s5_rst_outstanding", hasOutstanding, 0);
        mst_ready = 1'b0;
        @(negedge clk);
        #1;
        resetN = 1'b1;
        tick();

        // slave beat with nothing to fill, prefetch hit, promise saturation
        slv_valid = 1'b1; slv_data = 32'h1234; slv_last = 1'b0;
        tick();
        slv_valid = 1'b0;
        chk("s6_err2", errorCode, 2);
        do_alloc(32'h7000, 1'b1);
        do_alloc(32'h7000, 1'b1);
        chk("s6_err5", errorCode, 5);
        for (int i = 0; i < 7; i++) do_alloc(32'h7000, 1'b0);
        chk("s6_no_err", errorCode, 0);
        do_alloc(32'h7000, 1'b0);
        chk("s6_err6", errorCode, 6);
        chk("s6_pref_cnt", prefetchReqCnt, 0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/prefetch_burst_queue.md
PREFETCH_BURST_QUEUE -- requirements
Module: prefetch_burst_queue

Interface
REQ-001 SHALL have parameters (name, default, meaning): LOG_QUEUE_SIZE, 3, log2 of burst slots (QUEUE_SIZE = 2^LOG_QUEUE_SIZE).
REQ-002 SHALL have LOG_BURST_MAX, 2, log2 of beats per slot (BURST_MAX); DATA_BITS, 512, beat width; ADDR_BITS, 64, address width; PROMISE_WIDTH, 3, promise counter width.
REQ-003 SHALL use one clock and an asynchronous active-low reset: clk  in  1  rising-edge clock; resetN  in  1  async active-low reset.
REQ-004 SHALL have ports: burstLen  in  LOG_BURST_MAX  beats-1 per burst, static while non-empty; crs_almostFullSpacer  in  LOG_QUEUE_SIZE  almost-full margin in slots.
REQ-005 SHALL have ports: alloc_valid  in  1; alloc_ready  out  1; alloc_addr  in  ADDR_BITS  burst-aligned address; alloc_isPref  in  1  1=prefetch, 0=master read; alloc_hit  out  1  combinational lookup of alloc_addr.
REQ-006 SHALL have ports: slv_valid  in  1; slv_ready  out  1; slv_data  in  DATA_BITS; slv_last  in  1.
REQ-007 SHALL have ports: mst_valid  out  1; mst_ready  in  1; mst_data  out  DATA_BITS; mst_addr  out  ADDR_BITS  head slot address; mst_last  out  1.
REQ-008 SHALL have ports: flush  in  1; prefetchReqCnt  out  LOG_QUEUE_SIZE+1  unclaimed prefetch slots; validCnt  out  LOG_QUEUE_SIZE+1; almostFull  out  1; hasOutstanding  out  1; errorCode  out  3.

Function
REQ-009 Per slot state SHALL be: valid, isPref, addr, promise, beatValid[BURST_MAX]; head, tail, fill pointers wrap modulo QUEUE_SIZE.
REQ-010 alloc_hit SHALL be 1 iff a valid slot's addr equals alloc_addr; alloc_ready SHALL be 1 iff not full or alloc_hit.
REQ-011 Master alloc, hit: matching slot promise +1, isPref cleared, no new slot; miss: tail slot allocated with promise=1, isPref=0.
REQ-012 Prefetch alloc, miss: tail slot allocated with promise=0, isPref=1; hit: no state change, errorCode=5.
REQ-013 Master hit with promise at max (all ones): no change, errorCode=6.
REQ-014 Allocation SHALL clear all beatValid of the new slot; tail advances by 1.
REQ-015 slv_ready SHALL be 1 iff fill slot is valid and its data incomplete; beats write at fill slot, beat index 0..burstLen; at beat burstLen fill advances, beat index resets to 0.
REQ-016 slv_last SHALL equal (beat index == burstLen); mismatch: beat still written, errorCode=4. slv_valid with slv_ready=0: errorCode=2.
REQ-017 mst_valid SHALL be 1 iff head valid, head promise>0, beatValid[head][rdBeat]; mst_data/mst_last from that beat, mst_last = (rdBeat==burstLen).
REQ-018 On mst handshake rdBeat +1; at last beat rdBeat=0 and promise -1; head slot is retained (replay on next promise).
REQ-019 Head skip-pop: when head promise==0, head data complete, and slot head+1 is valid with promise>0, head SHALL be invalidated and head pointer +1 in that cycle; at most one pop per cycle.
REQ-020 Read latency: beat written at edge N SHALL be visible on mst_* after edge N (zero-cycle bypass not required).
REQ-021 Simultaneous alloc, slave write, master read and pop in one cycle SHALL all take effect; alloc hitting the slot being popped SHALL be treated as a hit and cancel the pop.
REQ-022 Full: validCnt==QUEUE_SIZE; empty: validCnt==0; almostFull = validCnt + crs_almostFullSpacer >= QUEUE_SIZE (LOG_QUEUE_SIZE+2-bit arithmetic, no overflow).
REQ-023 alloc_valid with alloc_ready=0: dropped, errorCode=3.
REQ-024 hasOutstanding SHALL be 1 iff any valid slot has incomplete data; prefetchReqCnt counts valid slots with isPref=1.
REQ-025 flush SHALL, next edge, invalidate all slots and zero all pointers and counters; flush overrides all other inputs that cycle; slave beats arriving after flush for pre-flush bursts are upstream's responsibility.
REQ-026 errorCode SHALL be registered, valid for one cycle, 0 otherwise; priority 2 > 3 > 4 > 5 > 6.

Reset
REQ-027 On resetN low, asynchronously: all slots invalid, pointers and beat indices 0, errorCode=0, mst_valid=0, slv_ready=0, alloc_ready=1, alloc_hit=0, validCnt=0, almostFull=(crs_almostFullSpacer>=QUEUE_SIZE), hasOutstanding=0; reset mid-burst discards all data.

Verification (LOG_QUEUE_SIZE=2, burstLen=3)
REQ-028 Master alloc 0x1000, 4 slave beats D0..D3 last on D3 -> mst emits D0..D3, mst_last on D3 only, then mst_valid=0.
REQ-029 Prefetch 0x1000, 4 beats, master alloc 0x1000 -> alloc_hit=1, validCnt=1, prefetchReqCnt 1->0, 4 beats delivered.
REQ-030 Prefetch 0x1000 complete, master alloc 0x2000 + 4 beats -> head 0x1000 skip-popped, 0x2000 beats delivered, validCnt ends 1.
REQ-031 4 allocations then 5th miss -> alloc_ready=0, errorCode=3 one cycle; 5th hitting 0x1000 -> accepted, promise=2, burst replayed twice.
REQ-032 slv_last on beat 1 -> errorCode=4; resetN low mid-read -> mst_valid=0, validCnt=0 immediately.
